rv_uart_tx: RTL and testbench

RV_UART_TX -- requirements
Module: rv_uart_tx

---
 rtl/rv_uart_tx.sv | 266 ++++++++++++++++++++++++++
 tb/tb_rv_uart_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_uart_tx.sv
// -----------------------------------------------------------------------------
// rv_uart_tx -- memory-mapped UART transmitter for a RISC-V data-memory bus.
//
// Purpose:
//   Presents an 8-byte register window on the CPU data-memory bus. A byte store
//   to TXDATA (offset 0x0) queues a character. The character is sent as 8N1:
//   one start bit, 8 data bits LSB-first, one stop bit, each g_clk_div clocks
//   long. STATUS (offset 0x4) reads back as:
//     bit0 FULL, bit1 BUSY, bit2 OVF (sticky), bits[11:8] buffer level.
//   Writing STATUS with lane 0 enabled and bit 2 set clears OVF.
//   Loads are registered: dm_data_l_o carries STATUS one cycle after the
//   address is presented, or zero for any other address. The integrator ORs it
//   with the RAM load data.
//
// Configuration macro:
//   URV_UART_TX_FIFO_EN -- when defined, the TX buffer is an 8-entry circular
//                          FIFO. Otherwise it is a single holding register.
//
// Parameters:
//   g_base_addr  byte address of the register window (8-byte aligned)
//   g_clk_div    clock cycles per serial bit (2..65535)
//
// Ports:
//   clk_i             clock, all logic on the rising edge
//   rst_i             synchronous active-high reset
//   dm_addr_i         CPU data-memory byte address
//   dm_data_s_i       CPU store data
//   dm_data_select_i  store byte-lane enables
//   dm_write_i        store strobe, one cycle per store
//   dm_data_l_o       registered load data
//   txd_o             registered serial line, idle high
//   busy_o            high while any byte is buffered or being shifted
// -----------------------------------------------------------------------------
module rv_uart_tx #(
  parameter logic [31:0] g_base_addr = 32'h0010_0000,
  parameter int unsigned g_clk_div   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_write_i,
  output logic [31:0] dm_data_l_o,
  output logic        txd_o,
  output logic        busy_o
);

  localparam int unsigned           LP_CNT_W    = $clog2(g_clk_div);
  localparam logic [LP_CNT_W-1:0]   LP_CNT_LAST = LP_CNT_W'(g_clk_div - 1);

`ifdef URV_UART_TX_FIFO_EN
  localparam logic [3:0] LP_DEPTH = 4'd8;
`else
  localparam logic [3:0] LP_DEPTH = 4'd1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  // Registers
  state_t                r_state;
  logic [LP_CNT_W-1:0]   r_cnt;
  logic [2:0]            r_bit_idx;
  logic [7:0]            r_shift;
  logic [3:0]            r_level;
  logic                  r_ovf;
  logic                  r_txd;
  logic                  r_busy;
  logic [31:0]           r_load;

  // Combinational signals
  state_t                w_state_next;
  logic [LP_CNT_W-1:0]   w_cnt_next;
  logic [2:0]            w_bit_next;
  logic                  w_txd_next;
  logic                  w_pop;
  logic                  w_in_window;
  logic                  w_sel_txdata;
  logic                  w_sel_status;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push_req;
  logic                  w_push;
  logic                  w_ovf_clr;
  logic                  w_busy;
  logic [31:0]           w_status;
  logic [7:0]            w_head;

  // Bus bits with no function in this block.
  logic                  w_unused;
  assign w_unused = ^{dm_addr_i[1:0], dm_data_s_i[31:8], dm_data_select_i[3:1]};

  // ---------------------------------------------------------------------------
  // Address decode and buffer control
  // ---------------------------------------------------------------------------
  assign w_in_window  = (dm_addr_i[31:3] == g_base_addr[31:3]);
  assign w_sel_txdata = w_in_window & ~dm_addr_i[2];
  assign w_sel_status = w_in_window &  dm_addr_i[2];

  assign w_full  = (r_level == LP_DEPTH);
  assign w_empty = (r_level == 4'd0);

  // FULL is judged on the pre-edge level, so a store that lands on the same
  // edge as a pop from a full buffer is still dropped.
  assign w_push_req = dm_write_i & w_sel_txdata & dm_data_select_i[0];
  assign w_push     = w_push_req & ~w_full;
  assign w_ovf_clr  = dm_write_i & w_sel_status & dm_data_select_i[0] & dm_data_s_i[2];

  assign w_busy   = (r_state != ST_IDLE) | ~w_empty;
  assign w_status = {20'h0, r_level, 5'h0, r_ovf, w_busy, w_full};

  // ---------------------------------------------------------------------------
  // Buffer storage
  // ---------------------------------------------------------------------------
  // NOTE: the data storage has no reset. Only the level/pointers decide what
  // is valid, so clearing the entries would add reset fan-out for nothing.
`ifdef URV_UART_TX_FIFO_EN
  logic [7:0] r_mem [8];
  logic [2:0] r_wr_ptr;
  logic [2:0] r_rd_ptr;

  // 3-bit pointers wrap from entry 7 back to 0 on their own.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 3'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= dm_data_s_i[7:0];
  end

  assign w_head = r_mem[r_rd_ptr];
`else
  logic [7:0] r_hold;

  always_ff @(posedge clk_i) begin
    if (w_push) r_hold <= dm_data_s_i[7:0];
  end

  assign w_head = r_hold;
`endif

  // ---------------------------------------------------------------------------
  // Transmit FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments so that all
  // registers see the pre-edge values of each other, whatever the block order.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM: next state, counters and line value
  // ---------------------------------------------------------------------------
  // txd_o is registered from the current state, so the line trails the state
  // by one cycle. That gives the two-edge push-to-start latency and exactly one
  // idle-high cycle between frames (the IDLE cycle between STOP and START).
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit_idx;
    w_txd_next   = 1'b1;
    w_pop        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        w_bit_next = '0;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_START;
        end
      end

      ST_START: begin
        w_txd_next = 1'b0;
        if (r_cnt == LP_CNT_LAST) begin
          w_cnt_next   = '0;
          w_state_next = ST_DATA;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      ST_DATA: begin
        w_txd_next = r_shift[r_bit_idx];
        if (r_cnt == LP_CNT_LAST) begin
          w_cnt_next = '0;
          if (r_bit_idx == 3'd7) begin
            w_bit_next   = '0;
            w_state_next = ST_STOP;
          end else begin
            w_bit_next = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      ST_STOP: begin
        w_txd_next = 1'b1;
        if (r_cnt == LP_CNT_LAST) begin
          w_cnt_next   = '0;
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_level   <= '0;
      r_ovf     <= 1'b0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
      r_load    <= '0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_next;
      r_txd     <= w_txd_next;
      r_busy    <= w_busy;
      r_load    <= w_sel_status ? w_status : 32'h0;

      if (w_pop) r_shift <= w_head;

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 4'd1;
        2'b01:   r_level <= r_level - 4'd1;
        default: r_level <= r_level;
      endcase

      // A dropped store sets OVF even if a clear arrives on the same edge.
      if (w_push_req && w_full) r_ovf <= 1'b1;
      else if (w_ovf_clr)       r_ovf <= 1'b0;
    end
  end

  assign txd_o       = r_txd;
  assign busy_o      = r_busy;
  assign dm_data_l_o = r_load;

endmodule

// File: tb/tb_rv_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_rv_uart_tx -- self-checking bench for rv_uart_tx (g_clk_div = 4).
//
// The driver applies one bus cycle per clock on the falling edge. A
// transaction-level reference model (a byte queue plus a "cycles left in the
// current frame" counter) predicts txd_o, busy_o and dm_data_l_o for the next
// rising edge and queues that prediction. A per-cycle monitor pops and compares
// after each rising edge. Accepted bytes also go to a second queue, which a
// frame decoder watching txd_o pops and compares for every complete frame.
// -----------------------------------------------------------------------------
module tb_rv_uart_tx;

  localparam int          DIV   = 4;
  localparam int          FRAME = 10 * DIV;
  localparam logic [31:0] BASE  = 32'h0010_0000;
`ifdef URV_UART_TX_FIFO_EN
  localparam int          DEPTH = 8;
`else
  localparam int          DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] dm_addr_i = '0;
  logic [31:0] dm_data_s_i = '0;
  logic [3:0]  dm_data_select_i = '0;
  logic        dm_write_i = 1'b0;
  logic [31:0] dm_data_l_o;
  logic        txd_o;
  logic        busy_o;

  always #5 clk = ~clk;

  rv_uart_tx #(
    .g_base_addr (BASE),
    .g_clk_div   (DIV)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .dm_addr_i        (dm_addr_i),
    .dm_data_s_i      (dm_data_s_i),
    .dm_data_select_i (dm_data_select_i),
    .dm_write_i       (dm_write_i),
    .dm_data_l_o      (dm_data_l_o),
    .txd_o            (txd_o),
    .busy_o           (busy_o)
  );

  typedef struct packed {
    logic        txd;
    logic        busy;
    logic [31:0] load;
  } exp_t;

  exp_t       exp_cyc[$];   // per-cycle predictions
  logic [7:0] exp_tx[$];    // accepted bytes not yet seen on the line

  // Reference model state
  logic [7:0] m_buf[$];
  int         m_cnt = 0;    // cycles left in the frame being sent, 0 = idle
  logic [7:0] m_cur = '0;
  logic       m_ovf = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Line level for the current model position: slot 0 start, 1..8 data, 9 stop.
  function automatic logic model_txd();
    int slot;
    if (m_cnt == 0) return 1'b1;
    slot = (FRAME - m_cnt) / DIV;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_cur[slot-1];
  endfunction

  // One bus cycle: drive inputs, predict outputs after the coming edge.
  task automatic step(input logic rst, input logic we, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] sel);
    exp_t e;
    logic busy_pre, full_pre, in_win, is_status, push_req, clr;
    @(negedge clk);
    rst_i            = rst;
    dm_write_i       = we;
    dm_addr_i        = addr;
    dm_data_s_i      = data;
    dm_data_select_i = sel;
    in_win    = ((addr & ~32'h7) == BASE);
    is_status = in_win && ((addr & 32'h4) != 0);
    if (rst) begin
      e.txd  = 1'b1;
      e.busy = 1'b0;
      e.load = 32'h0;
      m_buf.delete();
      exp_tx.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
    end else begin
      busy_pre = (m_cnt != 0) || (m_buf.size() != 0);
      full_pre = (m_buf.size() == DEPTH);
      e.txd  = model_txd();
      e.busy = busy_pre;
      e.load = is_status ? {20'h0, 4'(m_buf.size()), 5'h0, m_ovf, busy_pre, full_pre} : 32'h0;
      push_req = we && in_win && !is_status && sel[0];
      clr      = we && is_status && sel[0] && data[2];
      if (m_cnt == 0 && m_buf.size() != 0) begin
        m_cur = m_buf.pop_front();
        m_cnt = FRAME;
      end else if (m_cnt != 0) begin
        m_cnt--;
      end
      if (clr) m_ovf = 1'b0;
      if (push_req) begin
        if (full_pre) begin
          m_ovf = 1'b1;
        end else begin
          m_buf.push_back(data[7:0]);
          exp_tx.push_back(data[7:0]);
        end
      end
    end
    exp_cyc.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic rd(input logic [31:0] addr);
    step(1'b0, 1'b0, addr, 32'h0, 4'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
    step(1'b0, 1'b1, addr, data, sel);
  endtask

  // Idle until the model has nothing left to send; an expired bound is a failure.
  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (m_cnt == 0 && m_buf.size() == 0) break;
      idle(1);
    end
    check("drain_bound", {31'b0, (m_cnt != 0) || (m_buf.size() != 0)}, 32'h0);
    idle(2);
  endtask

  // Per-cycle monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_cyc.size() != 0) begin
        e = exp_cyc.pop_front();
        check("txd_o",       {31'b0, txd_o},  {31'b0, e.txd});
        check("busy_o",      {31'b0, busy_o}, {31'b0, e.busy});
        check("dm_data_l_o", dm_data_l_o,     e.load);
      end
    end
  end

  // Frame decoder: collects a whole frame from the first low sample.
  initial begin
    logic       smp [FRAME];
    logic       aborted;
    logic       shape_ok;
    logic [7:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_i && txd_o === 1'b0) begin
        smp[0]  = txd_o;
        aborted = 1'b0;
        for (int k = 1; k < FRAME; k++) begin
          @(posedge clk);
          #1;
          if (rst_i) begin
            aborted = 1'b1;
            break;
          end
          smp[k] = txd_o;
        end
        if (!aborted) begin
          shape_ok = 1'b1;
          for (int k = 0; k < FRAME; k++)
            if (smp[k] !== smp[(k / DIV) * DIV]) shape_ok = 1'b0;
          if (smp[9*DIV] !== 1'b1) shape_ok = 1'b0;
          for (int j = 0; j < 8; j++) got[j] = smp[(j + 1) * DIV];
          check("frame_shape", {31'b0, shape_ok}, 32'h1);
          check("frame_pending", {31'b0, exp_tx.size() != 0}, 32'h1);
          if (exp_tx.size() != 0) check("frame_byte", {24'h0, got}, {24'h0, exp_tx.pop_front()});
        end
      end
    end
  end

  // Stimulus
  initial begin
    int          r;
    logic [31:0] d;
    logic [3:0]  s;

    repeat (3) step(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    idle(3);

    // Single character, full frame and busy tail.
    wr(BASE, 32'h0000_0041, 4'b0001);
    idle(50);

    // Stores that must not push: wrong lane, address outside the window.
    wr(BASE, 32'h0000_0055, 4'b0010);
    wr(32'h0000_0000, 32'h0000_0066, 4'b1111);
    idle(8);

    // Ten back-to-back stores, then STATUS.
    for (int i = 0; i < 10; i++) wr(BASE, $urandom, 4'b0001);
    rd(BASE + 32'h4);
    drain();

    // Clear OVF, read it back; overflow again and read it back.
    rd(BASE + 32'h4);
    wr(BASE + 32'h4, 32'h0000_0004, 4'b0001);
    rd(BASE + 32'h4);
    for (int i = 0; i < DEPTH + 2; i++) wr(BASE, $urandom, 4'b0001);
    rd(BASE + 32'h4);
    wr(BASE + 32'h4, 32'h0000_0004, 4'b0001);
    rd(BASE + 32'h4);
    drain();

    // STATUS read mid-frame with bytes buffered, then a read elsewhere.
    wr(BASE, 32'h0000_00A5, 4'b0001);
    idle(8);
    wr(BASE, 32'h0000_003C, 4'b0001);
    wr(BASE, 32'h0000_00C3, 4'b0001);
    rd(BASE + 32'h4);
    rd(32'h0000_0100);
    drain();

    // Reset pulse during the data bits aborts the frame.
    wr(BASE, 32'h0000_00F0, 4'b0001);
    idle(12);
    step(1'b1, 1'b1, BASE, 32'h0000_0011, 4'b0001);
    idle(60);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if (r < 25)      wr(BASE + 32'($urandom_range(0, 3)), d, s);
      else if (r < 31) wr(BASE + 32'h4 + 32'($urandom_range(0, 3)), d, s);
      else if (r < 41) rd(BASE + 32'h4);
      else if (r < 46) wr($urandom, d, s);
      else if (r < 47) step(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
      else             idle(1);
    end
    drain();

    check("tx_all_sent", 32'(exp_tx.size()), 32'h0);
    @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
